instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Sequential MIPS instruction encoder: converts mnemonic-level requests into 32-bit instruction words, producing exactly the op/func encodings the CPU28 control decoder consumes.
- Expands pseudo-ops (NOP, MOVE, LI) and tags each output word with a sequential instruction-memory word address.
- Sits between the self-test program generator or debug loader and the instruction-memory write port.

Parameters:
- ADDR_W, 10, width of the output word-address counter.
- BASE_ADDR, 0, word address loaded on reset; truncated to ADDR_W bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted on the cycle when in_valid && in_ready
- in_mnem  in  5  mnemonic code (package enum)
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields
- in_imm  in  32  immediate: [15:0] for I-type, [25:0] for J/JAL, [31:0] for LI
- out_valid  out  1  instruction word valid
- out_ready  in  1  sink accepts the word
- out_instr  out  32  encoded word
- out_addr  out  ADDR_W  word address of out_instr
- err  out  1  sticky flag: an invalid mnemonic was accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, state=S_EMPTY.
- Handshake:
  - Output is valid/ready; out_instr and out_addr hold stable while out_valid && !out_ready.
  - A word transfers when out_valid && out_ready. out_addr increments by 1 after each transfer and wraps modulo 2^ADDR_W.
- FSM:
  - S_EMPTY: in_ready=1.
  - S_FULL: in_ready=out_ready, giving full throughput.
  - S_LI2: in_ready=0.
- Latency: one cycle from acceptance to out_valid.
- Transitions:
  - EMPTY/FULL, accept of a valid non-LI request -> FULL.
  - EMPTY/FULL, accept of LI -> LI2, presenting the LUI word.
  - LI2, on transfer -> FULL, presenting ORI rt,rt,imm[15:0].
  - FULL, transfer with no accept -> EMPTY.
- Encodings:
  - R-type: {6'd0, rs, rt, rd, shamt, func} with func SLL 0, SRL 2, SRA 3, JR 8, SYSCALL 12, ADD 32, ADDU 33, SUB 34, AND 36, OR 37, XOR 38, NOR 39, SLT 42, SLTU 43.
  - SLL/SRL/SRA force rs=0. ADD..SLTU force shamt=0.
  - JR = {0, rs, 15'd0, 6'd8}. SYSCALL = 32'h0000000C.
  - I-type: {op, rs, rt, imm[15:0]} with op BEQ 4, BNE 5, ADDI 8, ADDIU 9, SLTI 10, ANDI 12, ORI 13, XORI 14, LW 35, LHU 37, SW 43, LUI 15 (internal only).
  - BGEZ = {6'd1, rs, 5'd1, imm[15:0]}.
  - J/JAL = {op 2/3, imm[25:0]}.
  - Pseudo-ops: NOP=32'h0. MOVE = ADDU rd,rs,$0. LI = LUI rt,imm[31:16] followed by ORI rt,rt,imm[15:0].
  - Unused input fields are ignored, not passed through.
- Invalid code (31): the request is accepted, no word is emitted, err is set, out_addr is unchanged, and the state is unaffected apart from draining any word already held.
- Simultaneous transfer and accept in S_FULL: the new word loads in the same cycle and out_valid stays 1.
- Reset mid-LI: the pending ORI is discarded.

Optional Feature:
- Macro: ENC_LI_SHORT_EN.
- Defined: an LI whose imm[31:16]==0 emits a single ORI rt,$0,imm[15:0] and does not enter S_LI2.
- Undefined: every LI emits the two-word LUI+ORI pair.

Decomposition:
- Package instr_enc_pkg holds:
  - the 5-bit mnemonic enum (SLL..SW, NOP, MOVE, LI; 31 reserved);
  - OP_* and FUNC_* localparams;
  - the FSM state typedef.
- Sub-module instr_fields_enc: purely combinational, mnemonic plus fields -> {word0, word1, two_word, invalid}. The top level holds the FSM, output register and address counter.

Test Plan:
- ADDU rd=3 rs=1 rt=2 -> out_instr=0x00221821 at out_addr=0; a transfer after 1 cycle advances out_addr to 1.
- LI rt=8 imm=0x12345678 -> 0x3C081234 then 0x35085678 at consecutive addresses, with in_ready=0 during S_LI2. With ENC_LI_SHORT_EN and imm=0x00005678 -> single 0x34085678.
- SW rt=9 rs=29 imm=4 with out_ready held low 3 cycles -> 0xAFA90004 holds stable with out_addr unchanged and in_ready=0, then transfers.
- Back-to-back BGEZ rs=4 imm=0xFFFE and SYSCALL with out_ready=1 -> 0x0481FFFE then 0x0000000C on consecutive cycles, no bubble.
- in_mnem=31 -> err=1 stays set, no out_valid, out_addr unchanged; rst clears err.
- ADDR_W=2, 5 NOPs -> out_addr sequence 0,1,2,3,0; rst asserted mid-LI -> out_valid=0 and out_addr=BASE_ADDR next cycle.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: mnemonic codes, MIPS op/func encodings, encoder FSM states and word builders
package instr_enc_pkg;

    typedef enum logic [4:0] {
        M_SLL, M_SRL, M_SRA, M_JR, M_SYSCALL, M_ADD, M_ADDU, M_SUB, M_AND, M_OR,
        M_XOR, M_NOR, M_SLT, M_SLTU, M_J, M_JAL, M_BEQ, M_BNE, M_BGEZ, M_ADDI,
        M_ADDIU, M_SLTI, M_ANDI, M_ORI, M_XORI, M_LW, M_LHU, M_SW, M_NOP, M_MOVE,
        M_LI, M_INV = 5'd31
    } mnem_e;

    localparam logic [5:0] OP_RTYPE = 6'd0, OP_REGIMM = 6'd1, OP_J = 6'd2, OP_JAL = 6'd3,
                           OP_BEQ = 6'd4, OP_BNE = 6'd5, OP_ADDI = 6'd8, OP_ADDIU = 6'd9,
                           OP_SLTI = 6'd10, OP_ANDI = 6'd12, OP_ORI = 6'd13, OP_XORI = 6'd14,
                           OP_LUI = 6'd15, OP_LW = 6'd35, OP_LHU = 6'd37, OP_SW = 6'd43;

    localparam logic [5:0] FUNC_SLL = 6'd0, FUNC_SRL = 6'd2, FUNC_SRA = 6'd3, FUNC_JR = 6'd8,
                           FUNC_SYSCALL = 6'd12, FUNC_ADD = 6'd32, FUNC_ADDU = 6'd33,
                           FUNC_SUB = 6'd34, FUNC_AND = 6'd36, FUNC_OR = 6'd37, FUNC_XOR = 6'd38,
                           FUNC_NOR = 6'd39, FUNC_SLT = 6'd42, FUNC_SLTU = 6'd43;

    typedef enum logic [1:0] {S_EMPTY, S_FULL, S_LI2} state_e;

    function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                          logic [4:0] sh, logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                          logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request and instruction-word stream bundle of the instruction encoder
// slave  : encoder side (takes requests, drives words, in_ready and err)
// master : request source / instruction-memory sink side
interface instr_encoder_if #(parameter int ADDR_W = 10);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_mnem;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;

    modport slave (
        input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err
    );

    modport master (
        output in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err
    );
endinterface

// File: rtl/instr_fields_enc.sv
// instr_fields_enc: combinational mnemonic+fields -> instruction word(s)
// in : mnem, rs, rt, rd, shamt, imm
// out: word0 (first word), word1 (second word of LI), two_word, invalid
// ENC_LI_SHORT_EN: LI with imm[31:16]==0 becomes a single ORI rt,$0,imm
module instr_fields_enc
    import instr_enc_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [31:0] imm,
    output logic [31:0] word0,
    output logic [31:0] word1,
    output logic        two_word,
    output logic        invalid
);
    logic li_short;
`ifdef ENC_LI_SHORT_EN
    assign li_short = imm[31:16] == 16'd0;
`else
    assign li_short = 1'b0;
`endif
    assign word1 = itype(OP_ORI, rt, rt, imm[15:0]);

    always_comb begin
        word0 = '0;
        two_word = 1'b0;
        invalid = 1'b0;
        case (mnem_e'(mnem))
            M_SLL:     word0 = rtype(5'd0, rt, rd, shamt, FUNC_SLL);
            M_SRL:     word0 = rtype(5'd0, rt, rd, shamt, FUNC_SRL);
            M_SRA:     word0 = rtype(5'd0, rt, rd, shamt, FUNC_SRA);
            M_JR:      word0 = rtype(rs, 5'd0, 5'd0, 5'd0, FUNC_JR);
            M_SYSCALL: word0 = rtype(5'd0, 5'd0, 5'd0, 5'd0, FUNC_SYSCALL);
            M_ADD:     word0 = rtype(rs, rt, rd, 5'd0, FUNC_ADD);
            M_ADDU:    word0 = rtype(rs, rt, rd, 5'd0, FUNC_ADDU);
            M_SUB:     word0 = rtype(rs, rt, rd, 5'd0, FUNC_SUB);
            M_AND:     word0 = rtype(rs, rt, rd, 5'd0, FUNC_AND);
            M_OR:      word0 = rtype(rs, rt, rd, 5'd0, FUNC_OR);
            M_XOR:     word0 = rtype(rs, rt, rd, 5'd0, FUNC_XOR);
            M_NOR:     word0 = rtype(rs, rt, rd, 5'd0, FUNC_NOR);
            M_SLT:     word0 = rtype(rs, rt, rd, 5'd0, FUNC_SLT);
            M_SLTU:    word0 = rtype(rs, rt, rd, 5'd0, FUNC_SLTU);
            M_J:       word0 = {OP_J, imm[25:0]};
            M_JAL:     word0 = {OP_JAL, imm[25:0]};
            M_BEQ:     word0 = itype(OP_BEQ, rs, rt, imm[15:0]);
            M_BNE:     word0 = itype(OP_BNE, rs, rt, imm[15:0]);
            M_BGEZ:    word0 = itype(OP_REGIMM, rs, 5'd1, imm[15:0]);
            M_ADDI:    word0 = itype(OP_ADDI, rs, rt, imm[15:0]);
            M_ADDIU:   word0 = itype(OP_ADDIU, rs, rt, imm[15:0]);
            M_SLTI:    word0 = itype(OP_SLTI, rs, rt, imm[15:0]);
            M_ANDI:    word0 = itype(OP_ANDI, rs, rt, imm[15:0]);
            M_ORI:     word0 = itype(OP_ORI, rs, rt, imm[15:0]);
            M_XORI:    word0 = itype(OP_XORI, rs, rt, imm[15:0]);
            M_LW:      word0 = itype(OP_LW, rs, rt, imm[15:0]);
            M_LHU:     word0 = itype(OP_LHU, rs, rt, imm[15:0]);
            M_SW:      word0 = itype(OP_SW, rs, rt, imm[15:0]);
            M_NOP:     word0 = '0;
            M_MOVE:    word0 = rtype(rs, 5'd0, rd, 5'd0, FUNC_ADDU);
            M_LI: begin
                word0 = li_short ? itype(OP_ORI, 5'd0, rt, imm[15:0]) : itype(OP_LUI, 5'd0, rt, imm[31:16]);
                two_word = !li_short;
            end
            default:   invalid = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: mnemonic requests -> addressed 32-bit MIPS instruction words
// clk, rst : clock, synchronous active-high reset
// bus      : instr_encoder_if.slave (in_* request stream, out_* word stream, sticky err)
// ENC_LI_SHORT_EN (in instr_fields_enc): single-word LI when imm[31:16]==0
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input logic clk,
    input logic rst,
    instr_encoder_if.slave bus
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_e      state;
    logic [31:0] word0, word1, pend;
    logic        two_word, invalid, acc, xfer;

    instr_fields_enc u_fields (
        .mnem(bus.in_mnem), .rs(bus.in_rs), .rt(bus.in_rt), .rd(bus.in_rd),
        .shamt(bus.in_shamt), .imm(bus.in_imm),
        .word0(word0), .word1(word1), .two_word(two_word), .invalid(invalid)
    );

    assign bus.in_ready = (state == S_EMPTY) || (state == S_FULL && bus.out_ready);
    assign acc = bus.in_valid && bus.in_ready;
    assign xfer = bus.out_valid && bus.out_ready;

    // pend holds the ORI half of LI while the LUI half waits in the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
            bus.out_valid <= 1'b0;
            bus.out_instr <= '0;
            bus.out_addr <= BASE;
            bus.err <= 1'b0;
            pend <= '0;
        end else begin
            if (xfer) bus.out_addr <= bus.out_addr + ADDR_W'(1);
            if (acc && invalid) bus.err <= 1'b1;
            if (state == S_LI2) begin
                if (xfer) begin
                    bus.out_instr <= pend;
                    state <= S_FULL;
                end
            end else if (acc && !invalid) begin
                bus.out_instr <= word0;
                bus.out_valid <= 1'b1;
                pend <= word1;
                state <= two_word ? S_LI2 : S_FULL;
            end else if (xfer) begin
                bus.out_valid <= 1'b0;
                state <= S_EMPTY;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder (plus a 2-bit-address copy)
module tb_instr_encoder;
    import instr_enc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(10)) i0 ();
    instr_encoder_if #(.ADDR_W(2))  i1 ();

    assign i1.in_valid  = i0.in_valid;
    assign i1.in_mnem   = i0.in_mnem;
    assign i1.in_rs     = i0.in_rs;
    assign i1.in_rt     = i0.in_rt;
    assign i1.in_rd     = i0.in_rd;
    assign i1.in_shamt  = i0.in_shamt;
    assign i1.in_imm    = i0.in_imm;
    assign i1.out_ready = i0.out_ready;

    instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));
    instr_encoder #(.ADDR_W(2),  .BASE_ADDR(4)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));

    int compared = 0;
    int mismatched = 0;
    int ea = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [31:0] imm);
        i0.in_valid = 1'b1;
        i0.in_mnem = m;
        i0.in_rs = rs;
        i0.in_rt = rt;
        i0.in_rd = rd;
        i0.in_shamt = sh;
        i0.in_imm = imm;
    endtask

    task automatic chk_addr(input string tag);
        chk({tag, " addr"}, 32'(i0.out_addr), ea);
        chk({tag, " addr2"}, 32'(i1.out_addr), ea % 4);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] instr);
        chk({tag, " valid"}, 32'(i0.out_valid), 1);
        chk({tag, " instr"}, i0.out_instr, instr);
        chk_addr(tag);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " valid"}, 32'(i0.out_valid), 0);
        chk_addr(tag);
    endtask

    initial begin
        i0.out_ready = 1'b0;
        req(M_NOP, 0, 0, 0, 0, 0);
        i0.in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_idle("reset");
        chk("reset instr", i0.out_instr, 0);
        chk("reset err", 32'(i0.err), 0);
        chk("reset in_ready", 32'(i0.in_ready), 1);

        req(M_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 0);
        step();
        chk_out("addu", 32'h00221821);
        i0.in_valid = 1'b0;
        i0.out_ready = 1'b1;
        step();
        ea++;
        chk_idle("addu xfer");

        i0.out_ready = 1'b0;
        req(M_LI, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678);
        step();
        chk_out("li lui", 32'h3C081234);
        chk("li2 in_ready", 32'(i0.in_ready), 0);
        i0.in_valid = 1'b0;
        step();
        chk_out("li lui hold", 32'h3C081234);
        i0.out_ready = 1'b1;
        step();
        ea++;
        chk_out("li ori", 32'h35085678);
        chk("full in_ready", 32'(i0.in_ready), 1);
        step();
        ea++;
        chk_idle("li drain");

        req(M_LI, 5'd0, 5'd8, 5'd0, 5'd0, 32'h00005678);
        step();
        i0.in_valid = 1'b0;
`ifdef ENC_LI_SHORT_EN
        chk_out("li short", 32'h34085678);
        step();
        ea++;
`else
        chk_out("li0 lui", 32'h3C080000);
        step();
        ea++;
        chk_out("li0 ori", 32'h35085678);
        step();
        ea++;
`endif
        chk_idle("li0 drain");

        i0.out_ready = 1'b0;
        req(M_SW, 5'd29, 5'd9, 5'd0, 5'd0, 32'h4);
        step();
        chk_out("sw", 32'hAFA90004);
        req(M_ADD, 5'd6, 5'd7, 5'd5, 5'd3, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out("sw hold", 32'hAFA90004);
            chk("sw hold in_ready", 32'(i0.in_ready), 0);
        end
        i0.out_ready = 1'b1;
        step();
        ea++;
        chk_out("add", 32'h00C72820);
        req(M_BGEZ, 5'd4, 5'd7, 5'd0, 5'd0, 32'h0000FFFE);
        step();
        ea++;
        chk_out("bgez", 32'h0481FFFE);
        req(M_SYSCALL, 5'd3, 5'd4, 5'd5, 5'd6, 32'hFFFFFFFF);
        step();
        ea++;
        chk_out("syscall", 32'h0000000C);
        req(M_SLL, 5'd5, 5'd2, 5'd4, 5'd3, 0);
        step();
        ea++;
        chk_out("sll", 32'h000220C0);
        req(M_MOVE, 5'd1, 5'd9, 5'd3, 5'd7, 0);
        step();
        ea++;
        chk_out("move", 32'h00201821);
        req(M_J, 5'd1, 5'd1, 5'd1, 5'd1, 32'hFFABCDEF);
        step();
        ea++;
        chk_out("j", 32'h0BABCDEF);
        i0.in_valid = 1'b0;
        step();
        ea++;
        chk_idle("burst drain");

        req(5'd31, 0, 0, 0, 0, 0);
        step();
        i0.in_valid = 1'b0;
        chk("inv err", 32'(i0.err), 1);
        chk_idle("inv");
        step();
        chk("inv err sticky", 32'(i0.err), 1);
        chk_idle("inv later");
        req(M_NOP, 5'd3, 5'd3, 5'd3, 5'd3, 32'hFFFF);
        step();
        chk_out("nop", 0);
        req(5'd31, 0, 0, 0, 0, 0);
        step();
        i0.in_valid = 1'b0;
        ea++;
        chk_idle("inv while full");

        rst = 1'b1;
        step();
        rst = 1'b0;
        ea = 0;
        chk("rst err", 32'(i0.err), 0);
        chk_idle("rst");

        for (int k = 0; k < 5; k++) begin
            req(M_NOP, 5'd1, 5'd2, 5'd3, 5'd4, 32'hFFFF);
            step();
            if (k > 0) ea++;
            chk_out("nop seq", 0);
        end
        i0.in_valid = 1'b0;
        step();
        ea++;
        chk_idle("nop drain");

        i0.out_ready = 1'b0;
        req(M_LI, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678);
        step();
        chk("midli in_ready", 32'(i0.in_ready), 0);
        i0.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        ea = 0;
        chk_idle("midli rst");
        i0.out_ready = 1'b1;
        step();
        chk_idle("midli no ori");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
